// File: rtl/thor2023_imem_responder_pkg.sv
// Shared bus types and constants for the Thor2023 instruction-memory responder.
// Holds the Wishbone command/response layouts and the icache line geometry.
package thor2023_imem_responder_pkg;

   typedef logic [31:0] wb_address_t;
   typedef logic [7:0]  wb_tranid_t;
   typedef logic [3:0]  wb_cid_t;

   typedef enum logic [3:0] {
      CMD_NONE        = 4'd0,
      CMD_LOAD        = 4'd1,
      CMD_STORE       = 4'd2,
      CMD_ICACHE_LOAD = 4'd3,
      CMD_DCACHE_LOAD = 4'd4
   } wb_cmd_t;

   typedef struct packed {
      wb_cid_t      cid;
      wb_tranid_t   tid;
      wb_cmd_t      cmd;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      wb_address_t  vadr;
      logic [127:0] dat;
   } wb_cmd_request128_t;

   typedef struct packed {
      wb_cid_t      cid;
      wb_tranid_t   tid;
      logic         stall;
      logic         next;
      logic         ack;
      logic         rty;
      logic         err;
      logic [7:0]   pri;
      wb_address_t  adr;
      logic [127:0] dat;
   } wb_cmd_response128_t;

   localparam wb_address_t IMEM_BASE = 32'hFFFC0000;
   localparam int ICACHE_LINE_BYTES  = 32;
   localparam int LINE_LSB           = $clog2(ICACHE_LINE_BYTES);

   typedef logic [31-LINE_LSB:0] line_t;

   // One captured line request; half is the 16-byte half delivered first.
   typedef struct packed {
      line_t      line;
      wb_tranid_t tid;
      wb_cid_t    cid;
      logic       half;
   } imem_req_t;

   function automatic wb_address_t beat_adr(input line_t line, input logic half);
      return {line, half, 4'h0};
   endfunction

endpackage

// File: rtl/thor2023_imem_ram.sv
// Simple dual-port instruction RAM: write port A, registered read port B.
// A same-address read and write in one cycle returns the previous contents.
module thor2023_imem_ram #(
   parameter int AWID      = 12,
   parameter int DW        = 128,
   parameter     INIT_FILE = ""
) (
   input  logic            clk_i,
   input  logic            a_we_i,
   input  logic [AWID-1:0] a_adr_i,
   input  logic [DW-1:0]   a_dat_i,
   input  logic [AWID-1:0] b_adr_i,
   output logic [DW-1:0]   b_dat_o
);

   logic [DW-1:0] mem_q [2**AWID];

   always_ff @(posedge clk_i) begin
      if (a_we_i) mem_q[a_adr_i] <= a_dat_i;
      b_dat_o <= mem_q[b_adr_i];
   end

endmodule

// File: rtl/thor2023_imem_responder.sv
// Wishbone target for icache line loads: returns a 32-byte line as two 128-bit
// beats from on-chip RAM, with a one-deep pending slot and a snooping loader port.
module thor2023_imem_responder
   import thor2023_imem_responder_pkg::*;
#(
   parameter int          AWID      = 12,
   parameter wb_address_t BASE      = IMEM_BASE,
   parameter int          LAT       = 2,
   parameter              INIT_FILE = ""
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  wb_cmd_request128_t  wbs_req,
   output wb_cmd_response128_t wbs_resp,
   input  logic                ld_we,
   input  wb_address_t         ld_adr,
   input  logic [127:0]        ld_dat,
   output wb_address_t         snoop_adr,
   output logic                snoop_v
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_BEAT0, S_GAP, S_BEAT1
   } state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   imem_req_t    act_q, act_d, pend_q, pend_d, req_now;
   logic         act_v_q, act_v_d, pend_v_q, pend_v_d;
   logic         rty_v_q, rty_v_d, rty_new;
   wb_tranid_t   rty_tid_q, rty_tid_d;
   logic         snoop_v_q;
   wb_address_t  snoop_adr_q;
   logic         sel_hit, same_act, same_pend, accept, ack;
   logic         rd_half, beat_half;
   logic [127:0] ram_dat;
   logic         unused_req;

   assign unused_req = ^{wbs_req.sel, wbs_req.dat, wbs_req.vadr[3:0]};

   assign req_now.line = wbs_req.vadr[31:LINE_LSB];
   assign req_now.tid  = wbs_req.tid;
   assign req_now.cid  = wbs_req.cid;
   assign req_now.half = wbs_req.vadr[4];

   // Held cyc/stb would otherwise re-trigger; the active entry stays valid after its burst.
   assign sel_hit   = (wbs_req.vadr[31:AWID+4] == BASE[31:AWID+4]);
   assign same_act  = act_v_q  && (act_q.line  == req_now.line) && (act_q.tid  == req_now.tid);
   assign same_pend = pend_v_q && (pend_q.line == req_now.line) && (pend_q.tid == req_now.tid);
   assign accept    = wbs_req.cyc && wbs_req.stb && !wbs_req.we &&
                      (wbs_req.cmd == CMD_ICACHE_LOAD) && sel_hit && !same_act && !same_pend;

   assign ack       = (state_q == S_BEAT0) || (state_q == S_BEAT1);
   assign rd_half   = (state_q == S_GAP)   ? ~act_q.half : act_q.half;
   assign beat_half = (state_q == S_BEAT1) ? ~act_q.half : act_q.half;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_d     = act_q;
      act_v_d   = act_v_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      rty_v_d   = rty_v_q;
      rty_tid_d = rty_tid_q;
      rty_new   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pend_v_q) begin
               act_d   = pend_q;
               act_v_d = 1'b1;
               state_d = S_WAIT;
               cnt_d   = '0;
               if (accept) pend_d   = req_now;
               else        pend_v_d = 1'b0;
            end else if (accept) begin
               act_d   = req_now;
               act_v_d = 1'b1;
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (cnt_q == LAT_C) state_d = S_BEAT0;
            else                cnt_d   = cnt_q + 4'd1;
         end
         S_BEAT0: state_d = S_GAP;
         S_GAP:   state_d = S_BEAT1;
         S_BEAT1: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (accept && (state_q != S_IDLE)) begin
         if (!pend_v_q) begin
            pend_d   = req_now;
            pend_v_d = 1'b1;
         end else begin
            rty_new  = 1'b1;
         end
      end
      // A retry that collides with a beat is held over to the next (ack-free) cycle.
      if (rty_v_q && !ack) rty_v_d = 1'b0;
      if (rty_new) begin
         rty_v_d   = 1'b1;
         rty_tid_d = req_now.tid;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         act_v_q  <= 1'b0;
         pend_v_q <= 1'b0;
         rty_v_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         act_v_q  <= act_v_d;
         pend_v_q <= pend_v_d;
         rty_v_q  <= rty_v_d;
      end
   end

   always_ff @(posedge clk_i) begin
      act_q     <= act_d;
      pend_q    <= pend_d;
      rty_tid_q <= rty_tid_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         snoop_v_q   <= 1'b0;
         snoop_adr_q <= '0;
      end else begin
         snoop_v_q <= ld_we;
         if (ld_we) snoop_adr_q <= ld_adr;
      end
   end

   assign snoop_v   = snoop_v_q;
   assign snoop_adr = snoop_adr_q;

   thor2023_imem_ram #(
      .AWID      (AWID),
      .DW        (128),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk_i   (clk_i),
      .a_we_i  (ld_we),
      .a_adr_i (ld_adr[AWID+3:4]),
      .a_dat_i (ld_dat),
      .b_adr_i ({act_q.line[AWID-2:0], rd_half}),
      .b_dat_o (ram_dat)
   );

   always_comb begin
      wbs_resp = '0;
      if (ack) begin
         wbs_resp.ack = 1'b1;
         wbs_resp.dat = ram_dat;
         wbs_resp.adr = beat_adr(act_q.line, beat_half);
         wbs_resp.tid = act_q.tid;
         wbs_resp.cid = act_q.cid;
      end else if (rty_v_q) begin
         wbs_resp.rty = 1'b1;
         wbs_resp.tid = rty_tid_q;
      end
   end

endmodule

// File: tb/tb_thor2023_imem_responder.sv
// Bench for thor2023_imem_responder: directed scenarios then random traffic,
// all checked cycle by cycle against a schedule-based reference model.
module tb_thor2023_imem_responder;
   import thor2023_imem_responder_pkg::*;

   localparam int          AWID = 12;
   localparam int          LAT  = 2;
   localparam wb_address_t BASE = 32'hFFFC0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   wb_cmd_request128_t  req;
   wb_cmd_response128_t resp;
   logic                ld_we;
   wb_address_t         ld_adr;
   logic [127:0]        ld_dat;
   wb_address_t         snoop_adr;
   logic                snoop_v;

   thor2023_imem_responder #(.AWID(AWID), .BASE(BASE), .LAT(LAT), .INIT_FILE("")) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .wbs_req   (req),
      .wbs_resp  (resp),
      .ld_we     (ld_we),
      .ld_adr    (ld_adr),
      .ld_dat    (ld_dat),
      .snoop_adr (snoop_adr),
      .snoop_v   (snoop_v)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: a timetable of expected beats and retries keyed by cycle.
   typedef struct {
      logic [26:0] line;
      logic [7:0]  tid;
      logic [3:0]  cid;
      logic        half;
   } job_t;

   typedef struct {
      wb_address_t  adr;
      logic [127:0] dat;
      logic [7:0]   tid;
      logic [3:0]   cid;
      int           word;
   } beat_t;

   beat_t        exp_beat [int];
   logic [7:0]   exp_rty  [int];
   logic [127:0] ref_mem  [int];
   int           busy_end = -1;
   job_t         last, pend;
   bit           last_v = 0, pend_v = 0;
   bit           exp_sv = 0;
   wb_address_t  exp_sadr = '0;

   function automatic void start_job(input int c, input job_t j);
      for (int b = 0; b < 2; b++) begin
         beat_t bt;
         logic  h;
         h      = j.half ^ (b == 1);
         bt.adr = {j.line, h, 4'h0};
         bt.word = int'(j.line[AWID-2:0]) * 2 + int'(h);
         bt.tid = j.tid;
         bt.cid = j.cid;
         bt.dat = '0;
         exp_beat[c + LAT + 2 + 2*b] = bt;
      end
      busy_end = c + LAT + 4;
      last     = j;
      last_v   = 1;
   endfunction

   task automatic model_step(input int c);
      job_t r;
      bit   ok;
      if (exp_beat.exists(c + 1)) begin
         beat_t bt;
         bt     = exp_beat[c + 1];
         bt.dat = ref_mem.exists(bt.word) ? ref_mem[bt.word] : '0;
         exp_beat[c + 1] = bt;
      end
      if (ld_we) ref_mem[int'(ld_adr[AWID+3:4])] = ld_dat;
      if (rst) begin
         exp_beat.delete();
         exp_rty.delete();
         busy_end = -1;
         pend_v   = 0;
         last_v   = 0;
         exp_sv   = 0;
         exp_sadr = '0;
      end else begin
         exp_sv = ld_we;
         if (ld_we) exp_sadr = ld_adr;
         r.line = req.vadr[31:5];
         r.tid  = req.tid;
         r.cid  = req.cid;
         r.half = req.vadr[4];
         ok = req.cyc && req.stb && !req.we && (req.cmd == CMD_ICACHE_LOAD) &&
              ((req.vadr >> (AWID + 4)) == (BASE >> (AWID + 4))) &&
              !(last_v && last.line == r.line && last.tid == r.tid) &&
              !(pend_v && pend.line == r.line && pend.tid == r.tid);
         if (c > busy_end) begin
            if (pend_v) begin
               start_job(c, pend);
               if (ok) pend = r;
               else    pend_v = 0;
            end else if (ok) begin
               start_job(c, r);
            end
         end else if (ok) begin
            if (!pend_v) begin
               pend   = r;
               pend_v = 1;
            end else begin
               exp_rty[exp_beat.exists(c + 1) ? c + 2 : c + 1] = r.tid;
            end
         end
      end
   endtask

   task automatic check_outputs(input int c);
      beat_t      b;
      bit         a, ry;
      logic [7:0] etid;
      a  = exp_beat.exists(c);
      ry = !a && exp_rty.exists(c);
      b.adr = '0; b.dat = '0; b.tid = '0; b.cid = '0; b.word = 0;
      if (a) b = exp_beat[c];
      etid = a ? b.tid : (ry ? exp_rty[c] : 8'h00);
      check("ack",       128'(resp.ack), 128'(a));
      check("rty",       128'(resp.rty), 128'(ry));
      check("adr",       128'(resp.adr), 128'(b.adr));
      check("dat",       resp.dat,       b.dat);
      check("tid",       128'(resp.tid), 128'(etid));
      check("cid",       128'(resp.cid), 128'(b.cid));
      check("zero_fields", 128'({resp.stall, resp.next, resp.err, resp.pri}), 128'(0));
      check("snoop_v",   128'(snoop_v),   128'(exp_sv));
      check("snoop_adr", 128'(snoop_adr), 128'(exp_sadr));
      if (exp_beat.exists(c)) exp_beat.delete(c);
      if (exp_rty.exists(c))  exp_rty.delete(c);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         model_step(cyc);
         @(posedge clk);
         #1;
         cyc++;
         check_outputs(cyc);
      end
   endtask

   task automatic set_req(input wb_address_t a, input logic [7:0] tid, input logic [3:0] cid);
      req      = '0;
      req.cyc  = 1'b1;
      req.stb  = 1'b1;
      req.cmd  = CMD_ICACHE_LOAD;
      req.vadr = a;
      req.tid  = tid;
      req.cid  = cid;
      req.sel  = 16'hFFFF;
   endtask

   task automatic clr_req();
      req = '0;
   endtask

   initial begin
      int hold;
      req    = '0;
      rst    = 1'b1;
      ld_we  = 1'b0;
      ld_adr = '0;
      ld_dat = '0;
      tick(2);
      rst = 1'b0;
      tick(1);

      // Load the first 32 RAM words with back-to-back loader writes.
      for (int w = 0; w < 32; w++) begin
         ld_we  = 1'b1;
         ld_adr = BASE + 32'(w * 16);
         ld_dat = {$urandom, $urandom, $urandom, $urandom};
         tick(1);
      end
      ld_we = 1'b0;
      tick(2);

      set_req(BASE + 32'h40, 8'h21, 4'h1); tick(1); clr_req(); tick(10);
      set_req(BASE + 32'h50, 8'h22, 4'h2); tick(1); clr_req(); tick(10);

      set_req(BASE + 32'h80, 8'h11, 4'h3); tick(1); clr_req(); tick(1);
      set_req(BASE + 32'hA0, 8'h12, 4'h4); tick(1); clr_req(); tick(1);
      set_req(BASE + 32'hC0, 8'h13, 4'h5); tick(1); clr_req(); tick(20);

      set_req(BASE - 32'h20, 8'h30, 4'h6); tick(20); clr_req(); tick(2);
      set_req(BASE + 32'h60, 8'h31, 4'h7); tick(16); clr_req(); tick(5);

      set_req(BASE + 32'h40, 8'h32, 4'h8); tick(1); clr_req();
      ld_we  = 1'b1;
      ld_adr = BASE + 32'h40;
      ld_dat = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      tick(1);
      ld_we = 1'b0;
      tick(10);
      set_req(BASE + 32'h40, 8'h33, 4'h9); tick(1); clr_req(); tick(10);

      set_req(BASE + 32'h100, 8'h34, 4'hA); tick(1); clr_req(); tick(4);
      rst = 1'b1; tick(1); rst = 1'b0;
      tick(8);
      set_req(BASE + 32'h100, 8'h35, 4'hB); tick(1); clr_req(); tick(10);

      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               wb_address_t a;
               int          k;
               k = int'($urandom_range(0, 19));
               if (k == 0)      a = BASE - 32'($urandom_range(1, 8)) * 32'd32;
               else if (k == 1) a = 32'h00001000 + 32'($urandom_range(0, 255));
               else             a = BASE + 32'($urandom_range(0, 15)) * 32'd32 + 32'($urandom_range(0, 31));
               set_req(a, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
               if ($urandom_range(0, 9) == 0) req.cmd = CMD_LOAD;
               if ($urandom_range(0, 9) == 0) req.we  = 1'b1;
               hold = int'($urandom_range(1, 6));
            end else begin
               clr_req();
               hold = int'($urandom_range(1, 4));
            end
         end
         hold--;
         ld_we = ($urandom_range(0, 9) == 0);
         if (ld_we) begin
            ld_adr = BASE + 32'($urandom_range(0, 31)) * 32'd16 + 32'($urandom_range(0, 15));
            ld_dat = {$urandom, $urandom, $urandom, $urandom};
         end
         rst = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst   = 1'b0;
      ld_we = 1'b0;
      clr_req();
      tick(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
